// File: rtl/xeng_bl_order_gen_if.sv
// Label bus between the X-engine output stage and the baseline-order generator.
// The core side drives sync/en, the generator drives the antenna-pair labels.
interface xeng_bl_order_gen_if #(
  parameter int N_ANTS = 8
);
  localparam int ANT_BITS = $clog2(N_ANTS);

  logic                sync;
  logic                en;
  logic [ANT_BITS-1:0] ant_a;
  logic [ANT_BITS-1:0] ant_b;
  logic                buf_sel;

  modport master (
    output sync,
    output en,
    input  ant_a,
    input  ant_b,
    input  buf_sel
  );

  modport slave (
    input  sync,
    input  en,
    output ant_a,
    output ant_b,
    output buf_sel
  );
endinterface

// File: rtl/xeng_bl_order_gen.sv
// Baseline-order generator: labels each valid X-engine output word with its
// antenna pair and window-buffer select, decoded from an antenna/tap counter pair.
module xeng_bl_order_gen #(
  parameter int N_ANTS = 8
) (
  input  logic                clk,
  input  logic                rst,
  xeng_bl_order_gen_if.slave  bl_if
);
  localparam int ANT_BITS = $clog2(N_ANTS);
  localparam int N_TAPS   = N_ANTS / 2 + 1;
  localparam int TAP_BITS = $clog2(N_TAPS);

  logic [ANT_BITS-1:0] a_q, a_d;
  logic [TAP_BITS-1:0] t_q, t_d;
  logic [ANT_BITS:0]   sum_s;

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      t_q <= '0;
    end else begin
      a_q <= a_d;
      t_q <= t_d;
    end
  end

  // Next-state: sync clears, en advances tap (inner) then antenna; the
  // antenna counter's natural wrap at N_ANTS closes the frame with no gap.
  always_comb begin
    a_d = a_q;
    t_d = t_q;
    if (bl_if.sync) begin
      a_d = '0;
      t_d = '0;
    end else if (bl_if.en) begin
      if (t_q == TAP_BITS'(N_TAPS - 1)) begin
        t_d = '0;
        a_d = a_q + ANT_BITS'(1);
      end else begin
        t_d = t_q + TAP_BITS'(1);
        a_d = a_q;
      end
    end else begin
      a_d = a_q;
      t_d = t_q;
    end
  end

  // One extra bit keeps the carry that marks a previous-buffer baseline.
  assign sum_s         = (ANT_BITS + 1)'(a_q) + (ANT_BITS + 1)'(t_q);
  assign bl_if.ant_a   = a_q;
  assign bl_if.ant_b   = sum_s[ANT_BITS-1:0];
  assign bl_if.buf_sel = sum_s[ANT_BITS];
endmodule

// File: tb/tb_xeng_bl_order_gen.sv
// Self-checking bench for xeng_bl_order_gen: frame-index reference model,
// per-cycle comparison, directed label checks and randomized sync/en/rst.
module tb_xeng_bl_order_gen;
  localparam int N  = 8;
  localparam int NT = N / 2 + 1;
  localparam int FL = N * NT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   mk = 0;
  int   cap [0:40];
  int   bcount;

  xeng_bl_order_gen_if #(.N_ANTS(N)) bl ();

  xeng_bl_order_gen #(.N_ANTS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .bl_if (bl.slave)
  );

  always #5 clk = ~clk;

  function automatic int lbl(input int k);
    int a, t;
    a = k / NT;
    t = k % NT;
    return a * 100 + ((a + t) % N) * 10 + (((a + t) >= N) ? 1 : 0);
  endfunction

  function automatic int got();
    return int'(bl.ant_a) * 100 + int'(bl.ant_b) * 10 + int'(bl.buf_sel);
  endfunction

  task automatic chk(input string nm, input int g, input int e);
    n_checks++;
    if (g !== e) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (encoded a*100+b*10+sel)", nm, g, e);
    end
  endtask

  // Reference model: a single frame index k.
  always @(posedge clk or posedge rst) begin
    if (rst)          mk <= 0;
    else if (bl.sync) mk <= 0;
    else if (bl.en)   mk <= (mk + 1) % FL;
  end

  // Compare DUT label to the model on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) chk("model", got(), lbl(mk));
  end

  task automatic step(input logic s, input logic e);
    @(posedge clk);
    #1;
    bl.sync = s;
    bl.en   = e;
  endtask

  task automatic sync_pulse();
    step(1'b1, 1'b0);
  endtask

  initial begin
    int en_pat [0:5];
    int exp3   [0:5];
    bl.sync = 1'b0;
    bl.en   = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state holds with en=0
    repeat (4) begin
      @(negedge clk);
      chk("reset_state", got(), 0);
    end
    repeat (7) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset", got(), 0);
    #1 rst = 1'b0;

    // 2: sync then continuous en
    sync_pulse();
    step(1'b0, 1'b1);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      cap[c] = got();
    end
    step(1'b0, 1'b0);
    chk("c0", cap[0], 0);     chk("c1", cap[1], 10);
    chk("c2", cap[2], 20);    chk("c3", cap[3], 30);
    chk("c4", cap[4], 40);    chk("c5", cap[5], 110);
    chk("c19", cap[19], 370); chk("c21", cap[21], 450);
    chk("c24", cap[24], 401); chk("c36", cap[36], 701);
    chk("c39", cap[39], 731); chk("c40_wrap", cap[40], 0);

    // 3: en toggling
    en_pat = '{1, 0, 0, 1, 0, 1};
    exp3   = '{0, 10, 10, 10, 20, 20};
    sync_pulse();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, en_pat[c] != 0);
      @(negedge clk);
      chk($sformatf("toggle%0d", c), got(), exp3[c]);
    end

    // 4: mid-frame sync at k=17
    sync_pulse();
    repeat (17) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    chk("k17", got(), 350);
    step(1'b0, 1'b1);
    @(negedge clk);
    chk("after_sync", got(), 0);

    // 5: three frames, buf_sel population per frame
    sync_pulse();
    step(1'b0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      bcount = 0;
      for (int c = 0; c < FL; c++) begin
        @(negedge clk);
        bcount += int'(bl.buf_sel);
      end
      chk($sformatf("bufsel_frame%0d", f), bcount, N * (N - 2) / 8 + N / 2);
    end
    step(1'b0, 1'b0);

    // Randomized sync/en with occasional asynchronous reset pulses
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 chk("rand_async_reset", got(), 0);
        #1 rst = 1'b0;
      end
    end
    step(1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/xeng_bl_order_gen.md
# xeng_bl_order_gen

Baseline-order generator for the X-engine correlator output stream. Runs alongside the X-engine core and labels every valid accumulation output word with its antenna pair (`ant_a`, `ant_b`) and its window-buffer select (`buf_sel`). The labels let downstream packetisers and verification benches sort the triangular baseline set without decoding the data. It is driven by the core's `sync_out`/`vld_out` and is purely a counter/decoder: it has no data path.

## Interface
- `N_ANTS`, default 8: number of dual-pol antennas. Must be a power of two and at least 2.
- `ANT_BITS`, derived as $clog2(N_ANTS): width of the antenna index ports.
- `N_TAPS`, derived as N_ANTS/2+1: number of X-engine taps, including the auto tap.
- `FRAME_LEN`, derived as N_ANTS*N_TAPS: number of valid words per output frame (40 at the default).

- `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-high.
- `sync`, input, 1 bit: frame-alignment pulse, taken from the core's `sync_out`.
- `en`, input, 1 bit: the current output word is valid, taken from the core's `vld_out`.
- `ant_a`, output, ANT_BITS bits: first antenna of the current baseline.
- `ant_b`, output, ANT_BITS bits: second antenna of the current baseline.
- `buf_sel`, output, 1 bit: 1 when the baseline's second antenna comes from the previous (other) window buffer.

## Operation
- State is two registered counters:
  - antenna counter `a`, range 0..N_ANTS-1;
  - tap counter `t`, range 0..N_TAPS-1.
- Frame index is k = a*N_TAPS + t. The tap counter is the inner, fast counter.
- Output decode:
  - `ant_a` = a.
  - `ant_b` = (a + t) mod N_ANTS, i.e. the natural ANT_BITS wrap.
  - `buf_sel` = 1 iff a + t ≥ N_ANTS, evaluated with one extra bit, no wrap.
- Advance rule, applied at a rising edge with `en`=1 and `sync`=0:
  - if t < N_TAPS-1, t increments;
  - otherwise t returns to 0 and a increments;
  - at k = FRAME_LEN-1, both counters return to 0. The frame wraps with no gap, so back-to-back frames need no new sync.
- `en`=0: both counters hold, and the outputs hold.
- `sync`=1 at a rising edge: both counters clear to 0, whatever `en` is. `sync` dominates a simultaneous `en`.
- A sync cycle is not treated as a labelled data cycle. The first `en` cycle after the sync edge is labelled k=0.
- Mid-frame `sync`: the partial frame is abandoned and the next valid word is k=0.
- Reset: a=0, t=0, so `ant_a`=0, `ant_b`=0, `buf_sel`=0. Asserting reset mid-frame produces the same state immediately, since reset is asynchronous. After release, the first counted `en` cycle is k=0.
- For t=0 (auto tap), `ant_a`=`ant_b` and `buf_sel`=0.
- For t=N_ANTS/2, each baseline appears twice per frame, once with each buffer. Both copies are emitted. Removing duplicates is downstream's job.

## Timing
- Zero-latency labelling. Outputs are a combinational decode of the registered a/t, so in any cycle they describe the word presented on that same cycle with `en`=1. Consumers sample the label and the data on the same edge.
- Counter update happens at the edge that ends an `en` cycle. The next `en` cycle therefore shows the next label, regardless of how many `en`=0 cycles fall in between.
- No handshake or backpressure. `en` is trusted.
- No outputs change during `en`=0 cycles, except through `sync` or `rst`.

## Test plan
Use N_ANTS=8, so N_TAPS=5 and FRAME_LEN=40.
1. Assert `rst` and release with `en`=0 → (ant_a, ant_b, buf_sel) = (0,0,0) and stays there. Assert `rst` asynchronously between edges → outputs go to (0,0,0) before the next edge.
2. Pulse `sync` for 1 cycle, then hold `en`=1 continuously → labels per cycle:
   - cycles 0–4: (0,0,0) (0,1,0) (0,2,0) (0,3,0) (0,4,0);
   - cycle 5: (1,1,0);
   - cycle 19: (3,7,0);
   - cycle 21: (4,5,0);
   - cycle 24: (4,0,1);
   - cycle 36: (7,0,1);
   - cycle 39: (7,3,1);
   - cycle 40: (0,0,0), the frame wraps.
3. Toggle `en` 1,0,0,1,0,1 starting after sync → labels on the `en`=1 cycles are (0,0,0), (0,1,0), (0,2,0), and the outputs hold through the `en`=0 cycles.
4. Assert `sync` at k=17 while `en`=1 → the next `en` cycle shows (0,0,0).
5. Run 3 full frames → every frame reproduces the 40-entry sequence of scenario 2. Per frame, `buf_sel`=1 on exactly N(N-2)/8 + N/2 = 10 words.
